mem_data_pipe: RTL and testbench

Parametrised byte-lane data memory for the core's load/store path. It accepts one read or write request per cycle over a valid/ready handshake. Each request gets an in-order response after a configurable read latency, and a bounded response queue absorbs consumer backpressure. Byte write strobes allow sub-word stores; address range and alignment checking is optional.

---
 rtl/mem_data_pipe.sv | 138 +++++++++++++
 tb/tb_mem_data_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_data_pipe.sv
// Byte-lane data memory with valid/ready requests, RD_LAT-cycle in-order responses and a credit-limited response queue.
// Define MEM_DATA_PIPE_ERR_EN to enable address range / alignment fault reporting.
module mem_data_pipe #(
    parameter int    DATA_W    = 32,
    parameter int    ROWS      = 512,
    parameter int    RD_LAT    = 1,
    parameter string DATA_FILE = ""
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [31:0]            req_addr_i,
    input  logic [DATA_W/8-1:0]    req_be_i,
    input  logic [DATA_W-1:0]      req_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   rsp_err_o
);
    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);
    localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DEPTH = RD_LAT + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [ROWS];

    logic [CW-1:0]     r_cnt;
    logic              w_acc;
    logic              w_pop;
    logic              w_err;
    logic [31:0]       w_idx;
    logic [AW-1:0]     w_row;
    logic [DATA_W-1:0] w_p0_dat;
    logic              w_tail_vld;
    logic              w_tail_err;
    logic [DATA_W-1:0] w_tail_dat;

    // Credit limit: never more in flight than the response queue can hold.
    assign req_ready_o = (r_cnt < CW'(DEPTH));
    assign w_acc       = req_valid_i && req_ready_o && !rst_i;
    assign w_idx       = req_addr_i >> OFS_W;

`ifdef MEM_DATA_PIPE_ERR_EN
    assign w_err = (w_idx >= 32'(ROWS)) || (req_addr_i[OFS_W-1:0] != '0);
    assign w_row = AW'(w_idx);
`else
    logic w_unused_ofs;
    assign w_unused_ofs = ^req_addr_i[OFS_W-1:0];
    assign w_err        = 1'b0;
    assign w_row        = AW'(w_idx % 32'(ROWS));
`endif

    assign w_p0_dat = (req_we_i || w_err) ? '0 : r_mem[w_row];

    always_ff @(posedge clk_i) begin
        if (w_acc && req_we_i && !w_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (req_be_i[i]) r_mem[w_row][8*i +: 8] <= req_wdata_i[8*i +: 8];
            end
        end
    end

    // The acceptance edge is stage 1; the last stage writes straight into the queue.
    if (RD_LAT == 1) begin : g_nopipe
        assign w_tail_vld = w_acc;
        assign w_tail_dat = w_p0_dat;
        assign w_tail_err = w_err;
    end else begin : g_pipe
        logic [RD_LAT-1:1]             r_vld_pipe;
        logic [RD_LAT-1:1]             r_err_pipe;
        logic [RD_LAT-1:1][DATA_W-1:0] r_dat_pipe;

        always_ff @(posedge clk_i) begin
            r_dat_pipe[1] <= w_p0_dat;
            r_err_pipe[1] <= w_err;
            for (int k = 2; k < RD_LAT; k++) begin
                r_dat_pipe[k] <= r_dat_pipe[k-1];
                r_err_pipe[k] <= r_err_pipe[k-1];
            end
            if (rst_i) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe[1] <= w_acc;
                for (int k = 2; k < RD_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
            end
        end

        assign w_tail_vld = r_vld_pipe[RD_LAT-1];
        assign w_tail_dat = r_dat_pipe[RD_LAT-1];
        assign w_tail_err = r_err_pipe[RD_LAT-1];
    end

    logic [DATA_W-1:0] r_q_dat [DEPTH];
    logic              r_q_err [DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_qn;

    assign w_pop = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (w_tail_vld && !rst_i) begin
            r_q_dat[r_wp] <= w_tail_dat;
            r_q_err[r_wp] <= w_tail_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_qn  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_tail_vld) r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
            if (w_pop)      r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
            case ({w_tail_vld, w_pop})
                2'b10:   r_qn <= r_qn + CW'(1);
                2'b01:   r_qn <= r_qn - CW'(1);
                default: r_qn <= r_qn;
            endcase
            case ({w_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rsp_valid_o = (r_qn != '0);
    assign rsp_rdata_o = rsp_valid_o ? r_q_dat[r_rp] : '0;
    assign rsp_err_o   = rsp_valid_o ? r_q_err[r_rp] : 1'b0;

endmodule

// File: tb/tb_mem_data_pipe.sv
// Directed and randomized checks of mem_data_pipe against a queue/array reference model.
module tb_mem_data_pipe;
    localparam int DATA_W = 32;
    localparam int ROWS   = 64;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int n_chk = 0;
    int n_pass = 0;
    logic last_acc;
    logic [31:0] mm [ROWS];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    mem_data_pipe #(.DATA_W(DATA_W), .ROWS(ROWS), .RD_LAT(RD_LAT), .DATA_FILE("")) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_acc();
        logic [31:0] idx;
        logic        err;
        idx = req_addr >> 2;
`ifdef MEM_DATA_PIPE_ERR_EN
        err = (idx >= ROWS) || (req_addr[1:0] != 2'b00);
`else
        err = 1'b0;
        idx = idx % ROWS;
`endif
        if (req_we) begin
            if (!err)
                for (int i = 0; i < 4; i++)
                    if (req_be[i]) mm[idx][8*i +: 8] = req_wdata[8*i +: 8];
            exp_q.push_back({err, 32'h0});
        end else begin
            exp_q.push_back({err, err ? 32'h0 : mm[idx]});
        end
    endtask

    // Checks the current cycle, predicts the coming edge, then advances past it.
    task automatic cyc();
        logic pop;
        chk("ready", req_ready, exp_q.size() < RD_LAT + 1);
        if (rsp_valid) chk("rsp", {rsp_err, rsp_rdata}, exp_q.size() != 0 ? exp_q[0] : 33'bx);
        else           chk("idle_out", {rsp_err, rsp_rdata}, 33'h0);
        last_acc = req_valid && req_ready;
        pop      = rsp_valid && rsp_ready;
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (last_acc) model_acc();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = d;
        last_acc = 1'b0;
        for (int t = 0; t < 20 && !last_acc; t++) cyc();
        chk("send_accept", last_acc, 1'b1);
    endtask

    task automatic drain();
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) cyc();
        chk("drain", exp_q.size(), 0);
        cyc();
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_out", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);

        for (int r = 0; r < ROWS; r++) send(1'b1, 32'(r * 4), 4'hF, $urandom);
        drain();

        // Latency and write-then-read ordering
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
        cyc();
        chk("lat_acc_wr", last_acc, 1'b1);
        chk("lat_early", rsp_valid, 1'b0);
        req_we = 1'b0;
        cyc();
        chk("lat_acc_rd", last_acc, 1'b1);
        req_valid = 1'b0;
        chk("lat_wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 33'h0});
        cyc();
        chk("lat_rd_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'hDEADBEEF});
        drain();

        send(1'b1, 32'h10, 4'b0001, 32'h000000AA);
        send(1'b0, 32'h10, 4'h0, 32'h0);
        send(1'b1, 32'h10, 4'b0000, 32'h12345678);
        send(1'b0, 32'h10, 4'h0, 32'h0);
        drain();

        // Backpressure: credit limit, stable stalled output, ready recovery
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; n = 0;
        for (int i = 0; i < 6; i++) begin
            req_addr = 32'(i * 4 + 8);
            cyc();
            n += int'(last_acc);
        end
        chk("stall_accepts", n, RD_LAT + 1);
        chk("stall_ready", req_ready, 1'b0);
        req_valid = 1'b0; rsp_ready = 1'b1;
        cyc();
        chk("ready_after_pop", req_ready, 1'b1);
        drain();

        // Fault / wrap behaviour (model follows the build configuration)
        send(1'b0, 32'h12, 4'h0, 32'h0);
        send(1'b0, 32'(4 * ROWS), 4'h0, 32'h0);
        send(1'b1, 32'(4 * ROWS), 4'hF, 32'hCAFEF00D);
        send(1'b0, 32'h0, 4'h0, 32'h0);
        drain();

        // Reset with responses outstanding, plus a write at the reset edge
        rsp_ready = 1'b0;
        send(1'b0, 32'h4, 4'h0, 32'h0);
        send(1'b0, 32'h8, 4'h0, 32'h0);
        send(1'b0, 32'hC, 4'h0, 32'h0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_be = 4'hF; req_wdata = 32'h55555555;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        exp_q.delete();
        chk("rst_flush_valid", rsp_valid, 1'b0);
        chk("rst_flush_ready", req_ready, 1'b1);
        rsp_ready = 1'b1;
        send(1'b0, 32'h14, 4'h0, 32'h0);
        send(1'b0, 32'h4, 4'h0, 32'h0);
        drain();

        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 4) != 0) req_addr = 32'($urandom_range(0, ROWS - 1) * 4);
            else req_addr = 32'($urandom_range(0, 2 * ROWS - 1) * 4 + $urandom_range(0, 3));
            req_be    = 4'($urandom_range(0, 15));
            req_wdata = $urandom;
            cyc();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
